// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, ALU/mux encodings,
// the per-instruction control flags that travel down the pipe, and FSM states.
package ctrl_pkg;

  localparam int OPC_W_D   = 4;
  localparam int REG_W_D   = 2;
  localparam int ALUOP_W_D = 3;
  localparam int SRC2_W_D  = 3;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_SHIFT = 4'b0011;  // bit 3 is a don't-care
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;  // bit 3 is a don't-care
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ORI   = 3'b010;
  localparam logic [2:0] ALU_NAND  = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b100;

  localparam logic [2:0] SRC2_REG   = 3'b000;
  localparam logic [2:0] SRC2_BR    = 3'b010;
  localparam logic [2:0] SRC2_IMM   = 3'b011;
  localparam logic [2:0] SRC2_SHAMT = 3'b100;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_Z    = 2'd1,
    BR_NZ   = 2'd2,
    BR_PZ   = 2'd3
  } br_kind_t;

  typedef struct packed {
    logic     alu1;
    logic     alu3;
    logic     mem_read;
    logic     mem_write;
    logic     wb_write;
    logic     flag_write;
    br_kind_t br;
    logic     stop;
  } ctrl_flags_t;

  localparam ctrl_flags_t FLAGS_NONE = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fsm_state_t;

  function automatic logic br_taken(input br_kind_t br, input logic n, input logic z);
    case (br)
      BR_Z:    return z;
      BR_NZ:   return !z;
      BR_PZ:   return !n;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: turns the decode-stage opcode into the control
// word that is then carried through EX, MEM and WB.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = OPC_W_D,
  parameter int ALUOP_W = ALUOP_W_D,
  parameter int SRC2_W  = SRC2_W_D
) (
  input  logic [OPC_W-1:0]   opc,
  output ctrl_flags_t        flags,
  output logic [ALUOP_W-1:0] aluop,
  output logic [SRC2_W-1:0]  alu2
);

  logic [3:0] op;
  assign op = opc[3:0];

  always_comb begin
    flags      = FLAGS_NONE;
    flags.alu1 = 1'b1;
    aluop      = ALUOP_W'(ALU_ADD);
    alu2       = SRC2_W'(SRC2_REG);
    // ORI and SHIFT ignore the top opcode bit, so they are matched first.
    if (op[2:0] == OP_ORI[2:0]) begin
      aluop            = ALUOP_W'(ALU_ORI);
      alu2             = SRC2_W'(SRC2_IMM);
      flags.wb_write   = 1'b1;
      flags.flag_write = 1'b1;
    end else if (op[2:0] == OP_SHIFT[2:0]) begin
      aluop            = ALUOP_W'(ALU_SHIFT);
      alu2             = SRC2_W'(SRC2_SHAMT);
      flags.wb_write   = 1'b1;
      flags.flag_write = 1'b1;
    end else begin
      case (op)
        OP_LOAD: begin
          flags.alu3     = 1'b1;
          flags.mem_read = 1'b1;
          flags.wb_write = 1'b1;
        end
        OP_STORE: flags.mem_write = 1'b1;
        OP_ADD: begin
          flags.wb_write   = 1'b1;
          flags.flag_write = 1'b1;
        end
        OP_SUB: begin
          aluop            = ALUOP_W'(ALU_SUB);
          flags.wb_write   = 1'b1;
          flags.flag_write = 1'b1;
        end
        OP_NAND: begin
          aluop            = ALUOP_W'(ALU_NAND);
          flags.wb_write   = 1'b1;
          flags.flag_write = 1'b1;
        end
        OP_BZ: begin
          flags.alu1 = 1'b0;
          flags.br   = BR_Z;
          alu2       = SRC2_W'(SRC2_BR);
        end
        OP_BNZ: begin
          flags.alu1 = 1'b0;
          flags.br   = BR_NZ;
          alu2       = SRC2_W'(SRC2_BR);
        end
        OP_BPZ: begin
          flags.alu1 = 1'b0;
          flags.br   = BR_PZ;
          alu2       = SRC2_W'(SRC2_BR);
        end
        OP_STOP: flags.stop = 1'b1;
        default: ;  // NOP and unassigned opcodes
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: carries control words D->EX->MEM->WB, resolves branches
// in EX from internal N/Z flags, detects load-use hazards and handles STOP.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = OPC_W_D,
  parameter int REG_W   = REG_W_D,
  parameter int ALUOP_W = ALUOP_W_D,
  parameter int SRC2_W  = SRC2_W_D
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     d_valid,
  input  logic [OPC_W+2*REG_W-1:0] d_instr,
  input  logic                     alu_n,
  input  logic                     alu_z,
  output logic                     stall,
  output logic                     flush,
  output logic                     pc_sel,
  output logic                     ex_alu1,
  output logic                     ex_alu3,
  output logic [SRC2_W-1:0]        ex_alu2,
  output logic [ALUOP_W-1:0]       ex_aluop,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     wb_write,
  output logic [REG_W-1:0]         wb_reg,
  output logic                     halted
);

  // Decode handshake: the instruction on d_instr is consumed at a rising edge
  // when d_valid=1, stall=0 and flush=0; while stall=1 the fetch side holds
  // d_valid/d_instr unchanged, and flush=1 discards it.
  logic [OPC_W-1:0]   d_opc;
  logic [REG_W-1:0]   d_r1;
  logic [REG_W-1:0]   d_r2;
  ctrl_flags_t        d_flags;
  logic [ALUOP_W-1:0] d_aluop;
  logic [SRC2_W-1:0]  d_alu2;

  assign d_opc = d_instr[OPC_W-1:0];
  assign d_r2  = d_instr[OPC_W +: REG_W];
  assign d_r1  = d_instr[OPC_W+REG_W +: REG_W];

  ctrl_decode #(
    .OPC_W  (OPC_W),
    .ALUOP_W(ALUOP_W),
    .SRC2_W (SRC2_W)
  ) u_decode (
    .opc  (d_opc),
    .flags(d_flags),
    .aluop(d_aluop),
    .alu2 (d_alu2)
  );

  logic               ex_valid;
  ctrl_flags_t        ex_flags;
  logic [ALUOP_W-1:0] ex_aluop_q;
  logic [SRC2_W-1:0]  ex_alu2_q;
  logic [REG_W-1:0]   ex_r1;

  logic               mem_valid;
  logic               mem_rd_q;
  logic               mem_wr_q;
  logic               mem_wb_q;
  logic [REG_W-1:0]   mem_r1;

  logic               wb_valid;
  logic               wb_wb_q;
  logic [REG_W-1:0]   wb_r1;

  logic               flag_n;
  logic               flag_z;
  fsm_state_t         state;
  logic               halted_q;

  logic load_use;
  logic ex_stop;
  logic taken;
  logic d_accept;

  assign load_use = d_valid && ex_valid && ex_flags.mem_read &&
                    ((d_r1 == ex_r1) || (d_r2 == ex_r1));
  assign ex_stop  = ex_valid && ex_flags.stop;
  assign taken    = ex_valid && br_taken(ex_flags.br, flag_n, flag_z);

  // STOP in EX also holds decode so nothing younger than STOP executes.
  assign stall    = (state == ST_HALT) || (!taken && (load_use || ex_stop));
  assign flush    = taken;
  assign pc_sel   = !taken;
  assign d_accept = d_valid && !stall && !taken;

  assign ex_alu1   = ex_valid && ex_flags.alu1;
  assign ex_alu3   = ex_valid && ex_flags.alu3;
  assign ex_alu2   = ex_valid ? ex_alu2_q : '0;
  assign ex_aluop  = ex_valid ? ex_aluop_q : '0;
  assign mem_read  = mem_valid && mem_rd_q;
  assign mem_write = mem_valid && mem_wr_q;
  assign wb_write  = wb_valid && wb_wb_q;
  assign wb_reg    = wb_valid ? wb_r1 : '0;
  assign halted    = halted_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid   <= 1'b0;
      ex_flags   <= FLAGS_NONE;
      ex_aluop_q <= '0;
      ex_alu2_q  <= '0;
      ex_r1      <= '0;
      mem_valid  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_wb_q   <= 1'b0;
      mem_r1     <= '0;
      wb_valid   <= 1'b0;
      wb_wb_q    <= 1'b0;
      wb_r1      <= '0;
      flag_n     <= 1'b0;
      flag_z     <= 1'b0;
    end else begin
      ex_valid <= d_accept;
      if (d_accept) begin
        ex_flags   <= d_flags;
        ex_aluop_q <= d_aluop;
        ex_alu2_q  <= d_alu2;
        ex_r1      <= d_r1;
      end
      mem_valid <= ex_valid;
      mem_rd_q  <= ex_flags.mem_read;
      mem_wr_q  <= ex_flags.mem_write;
      mem_wb_q  <= ex_flags.wb_write;
      mem_r1    <= ex_r1;
      wb_valid  <= mem_valid;
      wb_wb_q   <= mem_wb_q;
      wb_r1     <= mem_r1;
      if (ex_valid && ex_flags.flag_write) begin
        flag_n <= alu_n;
        flag_z <= alu_z;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_stop) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else if (load_use && !taken) begin
            state <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (ex_stop) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_HALT: halted_q <= 1'b1;
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: directed hazard/branch/halt/reset scenarios plus a
// randomized stretch, every cycle compared against an instruction-level model.
module tb_pipe_ctrl_unit;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       d_valid;
  logic [7:0] d_instr;
  logic       alu_n;
  logic       alu_z;
  logic       stall, flush, pc_sel, ex_alu1, ex_alu3;
  logic [2:0] ex_alu2;
  logic [2:0] ex_aluop;
  logic       mem_read, mem_write, wb_write;
  logic [1:0] wb_reg;
  logic       halted;

  always #5 clock = ~clock;

  pipe_ctrl_unit dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .d_valid  (d_valid),
    .d_instr  (d_instr),
    .alu_n    (alu_n),
    .alu_z    (alu_z),
    .stall    (stall),
    .flush    (flush),
    .pc_sel   (pc_sel),
    .ex_alu1  (ex_alu1),
    .ex_alu3  (ex_alu3),
    .ex_alu2  (ex_alu2),
    .ex_aluop (ex_aluop),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .wb_write (wb_write),
    .wb_reg   (wb_reg),
    .halted   (halted)
  );

  localparam logic [3:0] I_LOAD = 4'b0000, I_STORE = 4'b0010, I_ADD = 4'b0100,
                         I_SUB = 4'b0110, I_BZ = 4'b0101, I_BNZ = 4'b1001,
                         I_STOP = 4'b0001, I_NOP = 4'b1010;
  // {stall,flush,pc_sel,alu1,alu3,alu2[3],aluop[3],mem_read,mem_write,wb_write,wb_reg[2],halted}
  localparam logic [16:0] RESET_VEC = 17'h04000;

  typedef enum int {K_LOAD, K_STORE, K_ADD, K_SUB, K_NAND, K_ORI, K_SHIFT,
                    K_BZ, K_BNZ, K_BPZ, K_STOP, K_NOP} kind_t;
  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic [1:0] r1;
  } slot_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  slot_t       pipe[$];  // [0]=EX, [1]=MEM, [2]=WB
  logic        m_n, m_z, m_halt;
  logic        exp_stall, exp_flush;
  logic [16:0] exp_vec;
  logic        obs_stall, obs_flush, obs_pc_sel;
  logic [1:0]  ra, rb;

  function automatic kind_t kind_of(input logic [3:0] op);
    casez (op)
      4'b?111: return K_ORI;
      4'b?011: return K_SHIFT;
      4'b0000: return K_LOAD;
      4'b0010: return K_STORE;
      4'b0100: return K_ADD;
      4'b0110: return K_SUB;
      4'b1000: return K_NAND;
      4'b0101: return K_BZ;
      4'b1001: return K_BNZ;
      4'b1101: return K_BPZ;
      4'b0001: return K_STOP;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic is_branch(input kind_t k);
    return (k == K_BZ) || (k == K_BNZ) || (k == K_BPZ);
  endfunction

  function automatic logic is_alu(input kind_t k);
    return (k == K_ADD) || (k == K_SUB) || (k == K_NAND) || (k == K_ORI) || (k == K_SHIFT);
  endfunction

  function automatic logic [2:0] aluop_of(input kind_t k);
    case (k)
      K_SUB:   return 3'b001;
      K_ORI:   return 3'b010;
      K_NAND:  return 3'b011;
      K_SHIFT: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] alu2_of(input kind_t k);
    if (k == K_ORI) return 3'b011;
    if (k == K_SHIFT) return 3'b100;
    if (is_branch(k)) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic taken_now(input kind_t k);
    case (k)
      K_BZ:    return m_z;
      K_BNZ:   return !m_z;
      K_BPZ:   return !m_n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] mk(input logic [3:0] op, input logic [1:0] r1, input logic [1:0] r2);
    return {r1, r2, op};
  endfunction

  function automatic logic [16:0] obs_now();
    return {stall, flush, pc_sel, ex_alu1, ex_alu3, ex_alu2, ex_aluop,
            mem_read, mem_write, wb_write, wb_reg, halted};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(slot_t'(0));
    m_n = 1'b0;
    m_z = 1'b0;
    m_halt = 1'b0;
  endtask

  task automatic model_eval();
    slot_t ex, mem, wb;
    kind_t ke;
    logic take, lu, stp;
    ex = pipe[0];
    mem = pipe[1];
    wb = pipe[2];
    ke = kind_of(ex.op);
    take = ex.v && taken_now(ke);
    lu = d_valid && ex.v && (ke == K_LOAD) && ((d_instr[7:6] == ex.r1) || (d_instr[5:4] == ex.r1));
    stp = ex.v && (ke == K_STOP);
    exp_flush = take;
    exp_stall = m_halt || (!take && (lu || stp));
    exp_vec = {exp_stall, take, !take,
               ex.v && !is_branch(ke), ex.v && (ke == K_LOAD),
               ex.v ? alu2_of(ke) : 3'b000, ex.v ? aluop_of(ke) : 3'b000,
               mem.v && (kind_of(mem.op) == K_LOAD), mem.v && (kind_of(mem.op) == K_STORE),
               wb.v && (is_alu(kind_of(wb.op)) || kind_of(wb.op) == K_LOAD),
               wb.v ? wb.r1 : 2'b00, m_halt};
  endtask

  task automatic model_advance();
    slot_t nw;
    if (pipe[0].v && is_alu(kind_of(pipe[0].op))) begin
      m_n = alu_n;
      m_z = alu_z;
    end
    if (pipe[0].v && kind_of(pipe[0].op) == K_STOP) m_halt = 1'b1;
    nw.v = d_valid && !exp_stall && !exp_flush;
    nw.op = d_instr[3:0];
    nw.r1 = d_instr[7:6];
    pipe.push_front(nw);
    void'(pipe.pop_back());
  endtask

  // Drive one decode-cycle of inputs, compare every output with the model,
  // then cross the clock edge. Leaves time at 1 unit after the edge.
  task automatic do_cycle(input logic dv, input logic [7:0] ins, input logic an,
                          input logic az, input string tag);
    d_valid = dv;
    d_instr = ins;
    alu_n = an;
    alu_z = az;
    #2;
    model_eval();
    obs_stall = stall;
    obs_flush = flush;
    obs_pc_sel = pc_sel;
    check(tag, obs_now(), exp_vec);
    @(posedge clock);
    model_advance();
    #1;
    cyc++;
  endtask

  task automatic step(input logic [3:0] op, input logic [1:0] r1, input logic [1:0] r2, input string tag);
    do_cycle(1'b1, mk(op, r1, r2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tag);
  endtask

  task automatic drain();
    repeat (3) do_cycle(1'b0, 8'h00, 1'b0, 1'b0, "drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] op;
    reset_n = 1'b0;
    d_valid = 1'b0;
    d_instr = 8'h00;
    alu_n = 1'b0;
    alu_z = 1'b0;
    model_reset();
    #3;
    model_eval();
    check("reset_model", obs_now(), exp_vec);
    check("reset_values", obs_now(), RESET_VEC);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // ADD then SUB back to back
    ra = 2'($urandom_range(0, 3));
    rb = 2'($urandom_range(0, 3));
    step(I_ADD, ra, 2'($urandom_range(0, 3)), "add_dec");
    check("add_ex_aluop", 17'(ex_aluop), 17'(3'b000));
    check("add_ex_alu1", 17'(ex_alu1), 17'(1'b1));
    step(I_SUB, rb, 2'($urandom_range(0, 3)), "sub_dec");
    check("sub_ex_aluop", 17'(ex_aluop), 17'(3'b001));
    step(I_NOP, 2'd0, 2'd0, "nop1");
    check("add_wb_write", 17'(wb_write), 17'(1'b1));
    check("add_wb_reg", 17'(wb_reg), 17'(ra));
    step(I_NOP, 2'd0, 2'd0, "nop2");
    check("sub_wb_write", 17'(wb_write), 17'(1'b1));
    check("sub_wb_reg", 17'(wb_reg), 17'(rb));
    step(I_NOP, 2'd0, 2'd0, "nop3");
    check("nop_wb_write", 17'(wb_write), 17'(1'b0));
    drain();

    // Load-use: LOAD R1=2 then ADD R2=2
    step(I_LOAD, 2'd2, 2'($urandom_range(0, 3)), "load_dec");
    check("load_ex_alu3", 17'(ex_alu3), 17'(1'b1));
    ra = 2'($urandom_range(0, 3));
    step(I_ADD, ra, 2'd2, "add_hazard");
    check("hazard_stall", 17'(obs_stall), 17'(1'b1));
    check("hazard_bubble", 17'(ex_alu1), 17'(1'b0));
    check("load_mem_read", 17'(mem_read), 17'(1'b1));
    step(I_ADD, ra, 2'd2, "add_retry");
    check("retry_stall", 17'(obs_stall), 17'(1'b0));
    check("retry_in_ex", 17'(ex_alu1), 17'(1'b1));
    drain();

    // SUB sets Z=1, BZ taken
    step(I_SUB, 2'd1, 2'd3, "sub_z1");
    do_cycle(1'b1, mk(I_BZ, 2'd0, 2'd0), 1'b0, 1'b1, "bz_dec");
    step(I_NOP, 2'd0, 2'd0, "bz_taken");
    check("bz_flush", 17'(obs_flush), 17'(1'b1));
    check("bz_pc_sel", 17'(obs_pc_sel), 17'(1'b0));
    check("bz_squash", 17'(ex_alu1), 17'(1'b0));
    step(I_NOP, 2'd0, 2'd0, "bz_after");
    check("bz_flush_once", 17'(obs_flush), 17'(1'b0));
    // SUB clears Z, BZ not taken
    step(I_SUB, 2'd1, 2'd3, "sub_z0");
    do_cycle(1'b1, mk(I_BZ, 2'd0, 2'd0), 1'b0, 1'b0, "bz_dec2");
    step(I_NOP, 2'd0, 2'd0, "bz_not_taken");
    check("bz_nt_flush", 17'(obs_flush), 17'(1'b0));
    check("bz_nt_pc_sel", 17'(obs_pc_sel), 17'(1'b1));
    check("bz_nt_next_in_ex", 17'(ex_alu1), 17'(1'b1));

    // BNZ taken (Z=0) while decode holds a register-reading instruction
    step(I_BNZ, 2'd3, 2'd3, "bnz_dec");
    step(I_ADD, 2'd3, 2'd3, "bnz_taken");
    check("bnz_flush", 17'(obs_flush), 17'(1'b1));
    check("bnz_no_stall", 17'(obs_stall), 17'(1'b0));
    drain();

    // Randomized traffic without STOP
    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == I_STOP) op = I_LOAD;
      do_cycle(1'($urandom_range(0, 3) != 0), mk(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end
    drain();

    // Reset asserted during a load-use stall
    step(I_LOAD, 2'd1, 2'd0, "load_pre_reset");
    d_valid = 1'b1;
    d_instr = mk(I_ADD, 2'd1, 2'd0);
    #2;
    check("stall_before_reset", 17'(stall), 17'(1'b1));
    reset_n = 1'b0;
    #1;
    check("async_reset", obs_now(), RESET_VEC);
    @(posedge clock);
    #1;
    check("reset_held", obs_now(), RESET_VEC);
    reset_n = 1'b1;
    model_reset();
    cyc++;
    step(I_ADD, 2'd1, 2'd0, "resume_add");
    check("resume_in_ex", 17'(ex_aluop), 17'(3'b000));
    check("resume_alu1", 17'(ex_alu1), 17'(1'b1));
    drain();

    // STORE then STOP: halt with the store still draining
    step(I_STORE, 2'd2, 2'd1, "store_dec");
    step(I_STOP, 2'd0, 2'd0, "stop_dec");
    check("store_mem_write", 17'(mem_write), 17'(1'b1));
    step(I_ADD, 2'd0, 2'd0, "stop_in_ex");
    check("halted_set", 17'(halted), 17'(1'b1));
    for (int i = 0; i < 6; i++) begin
      step(4'($urandom_range(2, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "halt_hold");
    end
    check("halted_persist", 17'(halted), 17'(1'b1));
    check("halt_stall", 17'(obs_stall), 17'(1'b1));

    // Only reset leaves HALT
    reset_n = 1'b0;
    #1;
    check("halt_reset", obs_now(), RESET_VEC);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_reset();
    cyc++;
    step(I_SUB, 2'd2, 2'd2, "post_halt");
    check("post_halt_aluop", 17'(ex_aluop), 17'(3'b001));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
